// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Arbitrates instruction fetch and data load/store onto one
//               external memory port with a request/ready handshake. Holds
//               one pending fetch and one pending data op and aborts hung
//               accesses after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 255,
    parameter int DATA_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic [1:0]        dmem_op,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_done,
    output logic              busy,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic [2:0]        ext_drive,
    input  logic              ext_ready,
    output logic              ext_timeout
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_READ  = 2'd2;
    localparam logic [1:0] c_ST_WRITE = 2'd3;

    localparam logic [2:0] c_DRV_IDLE  = 3'b000;
    localparam logic [2:0] c_DRV_FETCH = 3'b001;
    localparam logic [2:0] c_DRV_READ  = 3'b010;
    localparam logic [2:0] c_DRV_WRITE = 3'b011;

    logic [1:0]        r_state, w_state_nxt;
    logic              r_f_full, w_f_full_nxt;
    logic [ADDR_W-1:0] r_f_addr;
    logic              r_d_full, w_d_full_nxt;
    logic              r_d_write;
    logic [ADDR_W-1:0] r_d_addr;
    logic [DATA_W-1:0] r_d_wdata;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]        r_ext_drive, w_drive_nxt;
    logic [ADDR_W-1:0] r_ext_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_ext_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_instr, w_instr_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_ivalid, w_ivalid_nxt;
    logic              r_done, w_done_nxt;
    logic              r_timeout, w_timeout_nxt;

    // Slot contents as seen this cycle, including a request captured right now
    logic              w_fetch_new, w_data_new;
    logic              w_f_full, w_d_full, w_d_write;
    logic [ADDR_W-1:0] w_f_addr, w_d_addr;
    logic [DATA_W-1:0] w_d_wdata;

    // Capture new requests into empty slots, then decide issue/complete/abort
    always_comb begin
        w_fetch_new = fetch_req & ~r_f_full;
        w_data_new  = ((dmem_op == 2'b01) || (dmem_op == 2'b10)) & ~r_d_full;
        w_f_full    = r_f_full | w_fetch_new;
        w_f_addr    = w_fetch_new ? fetch_addr : r_f_addr;
        w_d_full    = r_d_full | w_data_new;
        w_d_write   = w_data_new ? (dmem_op == 2'b10) : r_d_write;
        w_d_addr    = w_data_new ? dmem_addr  : r_d_addr;
        w_d_wdata   = w_data_new ? dmem_wdata : r_d_wdata;

        w_state_nxt   = r_state;
        w_f_full_nxt  = w_f_full;
        w_d_full_nxt  = w_d_full;
        w_cnt_nxt     = r_cnt;
        w_drive_nxt   = r_ext_drive;
        w_addr_nxt    = r_ext_addr;
        w_wdata_nxt   = r_ext_wdata;
        w_instr_nxt   = r_instr;
        w_rdata_nxt   = r_rdata;
        w_ivalid_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;

        if (r_state == c_ST_IDLE) begin
            // A pending data op goes first unless fetch has priority and is waiting
            if (w_d_full && ((DATA_PRIO != 0) || !w_f_full)) begin
                w_d_full_nxt = 1'b0;
                w_state_nxt  = w_d_write ? c_ST_WRITE : c_ST_READ;
                w_drive_nxt  = w_d_write ? c_DRV_WRITE : c_DRV_READ;
                w_addr_nxt   = w_d_addr;
                w_wdata_nxt  = w_d_wdata;
                w_cnt_nxt    = '0;
            end else if (w_f_full) begin
                w_f_full_nxt = 1'b0;
                w_state_nxt  = c_ST_FETCH;
                w_drive_nxt  = c_DRV_FETCH;
                w_addr_nxt   = w_f_addr;
                w_cnt_nxt    = '0;
            end
        end else if (ext_ready) begin
            w_state_nxt = c_ST_IDLE;
            w_drive_nxt = c_DRV_IDLE;
            if (r_state == c_ST_FETCH) begin
                w_instr_nxt  = ext_rdata;
                w_ivalid_nxt = 1'b1;
            end else if (r_state == c_ST_READ) begin
                w_rdata_nxt = ext_rdata;
                w_done_nxt  = 1'b1;
            end else begin
                w_done_nxt = 1'b1;
            end
        end else if (r_cnt == c_CNT_LAST) begin
            // Hung access: drop it without a result pulse
            w_state_nxt   = c_ST_IDLE;
            w_drive_nxt   = c_DRV_IDLE;
            w_timeout_nxt = 1'b1;
        end else begin
            w_cnt_nxt = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_W'(1);
        end
    end

    // State, slot and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_f_full    <= 1'b0;
            r_f_addr    <= '0;
            r_d_full    <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_addr    <= '0;
            r_d_wdata   <= '0;
            r_cnt       <= '0;
            r_ext_drive <= c_DRV_IDLE;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_instr     <= '0;
            r_rdata     <= '0;
            r_ivalid    <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_f_full    <= w_f_full_nxt;
            r_f_addr    <= w_f_addr;
            r_d_full    <= w_d_full_nxt;
            r_d_write   <= w_d_write;
            r_d_addr    <= w_d_addr;
            r_d_wdata   <= w_d_wdata;
            r_cnt       <= w_cnt_nxt;
            r_ext_drive <= w_drive_nxt;
            r_ext_addr  <= w_addr_nxt;
            r_ext_wdata <= w_wdata_nxt;
            r_instr     <= w_instr_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ivalid    <= w_ivalid_nxt;
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign instr_out   = r_instr;
    assign instr_valid = r_ivalid;
    assign dmem_rdata  = r_rdata;
    assign dmem_done   = r_done;
    assign ext_addr    = r_ext_addr;
    assign ext_wdata   = r_ext_wdata;
    assign ext_drive   = r_ext_drive;
    assign ext_timeout = r_timeout;
    assign busy        = (r_state != c_ST_IDLE) | r_f_full | r_d_full;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl. Directed scenarios
//               followed by random traffic, compared every cycle against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int c_TO   = 4;
    localparam int c_PRIO = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [1:0]  dmem_op;
    logic [31:0] dmem_addr, dmem_wdata, ext_rdata;
    logic        ext_ready;

    logic [31:0] instr_out, dmem_rdata, ext_addr, ext_wdata;
    logic        instr_valid, dmem_done, busy, ext_timeout;
    logic [2:0]  ext_drive;

    logic [31:0] instr_out0, dmem_rdata0, ext_addr0, ext_wdata0;
    logic        instr_valid0, dmem_done0, busy0, ext_timeout0;
    logic [2:0]  ext_drive0;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(c_TO), .DATA_PRIO(c_PRIO)) u_dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .instr_out(instr_out), .instr_valid(instr_valid), .dmem_op(dmem_op),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_done(dmem_done), .busy(busy), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_drive(ext_drive), .ext_ready(ext_ready),
        .ext_timeout(ext_timeout)
    );

    // Fetch-priority variant, used only to confirm the reversed issue order
    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(c_TO), .DATA_PRIO(0)) u_dut0 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .instr_out(instr_out0), .instr_valid(instr_valid0), .dmem_op(dmem_op),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata0),
        .dmem_done(dmem_done0), .busy(busy0), .ext_addr(ext_addr0), .ext_wdata(ext_wdata0),
        .ext_rdata(ext_rdata), .ext_drive(ext_drive0), .ext_ready(ext_ready),
        .ext_timeout(ext_timeout0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the access in progress (kind 0 = none, else its
    // ext_drive code), its waited edges, and the two single-entry queues
    logic [2:0]  m_kind;
    int          m_age;
    logic        pf_v, pd_v;
    logic [31:0] pf_a, pd_a, pd_w;
    logic [2:0]  pd_kind;
    logic [31:0] e_addr, e_wdata, e_instr, e_rdata;
    logic        e_iv, e_done, e_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_kind = 3'd0; m_age = 0; pf_v = 1'b0; pd_v = 1'b0;
        pf_a = '0; pd_a = '0; pd_w = '0; pd_kind = 3'd0;
        e_addr = '0; e_wdata = '0; e_instr = '0; e_rdata = '0;
        e_iv = 1'b0; e_done = 1'b0; e_to = 1'b0;
    endtask

    task automatic model_step();
        e_iv = 1'b0; e_done = 1'b0; e_to = 1'b0;
        if (fetch_req && !pf_v) begin
            pf_v = 1'b1; pf_a = fetch_addr;
        end
        if ((dmem_op == 2'd1 || dmem_op == 2'd2) && !pd_v) begin
            pd_v = 1'b1; pd_kind = (dmem_op == 2'd1) ? 3'd2 : 3'd3;
            pd_a = dmem_addr; pd_w = dmem_wdata;
        end
        if (m_kind == 3'd0) begin
            if (pd_v && (c_PRIO == 1 || !pf_v)) begin
                m_kind = pd_kind; e_addr = pd_a; e_wdata = pd_w; pd_v = 1'b0; m_age = 0;
            end else if (pf_v) begin
                m_kind = 3'd1; e_addr = pf_a; pf_v = 1'b0; m_age = 0;
            end
        end else if (ext_ready) begin
            if (m_kind == 3'd1) begin e_instr = ext_rdata; e_iv = 1'b1; end
            else if (m_kind == 3'd2) begin e_rdata = ext_rdata; e_done = 1'b1; end
            else e_done = 1'b1;
            m_kind = 3'd0;
        end else begin
            m_age++;
            if (m_age == c_TO) begin m_kind = 3'd0; e_to = 1'b1; end
        end
    endtask

    task automatic check_all();
        check("ext_drive",   32'(ext_drive),   32'(m_kind));
        check("busy",        32'(busy),        32'(m_kind != 3'd0 || pf_v || pd_v));
        check("instr_valid", 32'(instr_valid), 32'(e_iv));
        check("dmem_done",   32'(dmem_done),   32'(e_done));
        check("ext_timeout", 32'(ext_timeout), 32'(e_to));
        check("instr_out",   instr_out,        e_instr);
        check("dmem_rdata",  dmem_rdata,       e_rdata);
        if (m_kind != 3'd0) check("ext_addr", ext_addr, e_addr);
        if (m_kind == 3'd3) check("ext_wdata", ext_wdata, e_wdata);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; dmem_op = 2'd0;
        dmem_addr = '0; dmem_wdata = '0; ext_rdata = '0; ext_ready = 1'b0;
        model_reset();
        tick();
        check("rst_drive", 32'(ext_drive), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_instr", instr_out,      32'd0);
        check("rst_addr",  ext_addr,       32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Fetch with ready after a few cycles
        fetch_req = 1'b1; fetch_addr = 32'h100;
        tick();
        fetch_req = 1'b0;
        check("f1_addr", ext_addr, 32'h100);
        cnt = (ext_drive == 3'b001) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ext_drive == 3'b001) cnt++;
        end
        ext_ready = 1'b1; ext_rdata = 32'hDEADBEEF;
        tick();
        ext_ready = 1'b0;
        check("f1_cycles", 32'(cnt), 32'd4);
        check("f1_instr", instr_out, 32'hDEADBEEF);
        check("f1_valid", 32'(instr_valid), 32'd1);
        tick();
        check("f1_pulse_end", 32'(instr_valid), 32'd0);

        // Store then load at the same address
        dmem_op = 2'd2; dmem_addr = 32'h40; dmem_wdata = 32'h12345678;
        tick();
        dmem_op = 2'd0;
        check("wr_drive", 32'(ext_drive), 32'd3);
        check("wr_wdata", ext_wdata, 32'h12345678);
        ext_ready = 1'b1; ext_rdata = '0;
        tick();
        ext_ready = 1'b0;
        check("wr_done", 32'(dmem_done), 32'd1);
        tick();
        dmem_op = 2'd1; dmem_addr = 32'h40;
        tick();
        dmem_op = 2'd0;
        check("rd_drive", 32'(ext_drive), 32'd2);
        ext_ready = 1'b1; ext_rdata = 32'h12345678;
        tick();
        ext_ready = 1'b0;
        check("rd_data", dmem_rdata, 32'h12345678);
        check("rd_done", 32'(dmem_done), 32'd1);
        tick();

        // Simultaneous fetch and read: order depends on priority
        fetch_req = 1'b1; fetch_addr = 32'h200; dmem_op = 2'd1; dmem_addr = 32'h80;
        tick();
        fetch_req = 1'b0; dmem_op = 2'd0;
        check("c_first_p1", 32'(ext_drive), 32'd2);
        check("c_first_p0", 32'(ext_drive0), 32'd1);
        check("c_addr_p0", ext_addr0, 32'h200);
        ext_ready = 1'b1; ext_rdata = 32'hA5A5A5A5;
        tick();
        ext_ready = 1'b0;
        check("c_gap_drive", 32'(ext_drive), 32'd0);
        check("c_gap_busy", 32'(busy), 32'd1);
        tick();
        check("c_second_p1", 32'(ext_drive), 32'd1);
        check("c_second_p0", 32'(ext_drive0), 32'd2);
        check("c_addr2_p0", ext_addr0, 32'h80);
        ext_ready = 1'b1; ext_rdata = 32'h5A5A5A5A;
        tick();
        ext_ready = 1'b0;
        tick();

        // Timeout with ready never arriving, then a late ready
        fetch_req = 1'b1; fetch_addr = 32'h300;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("to_still_drive", 32'(ext_drive), 32'd1);
        tick();
        check("to_drive", 32'(ext_drive), 32'd0);
        check("to_pulse", 32'(ext_timeout), 32'd1);
        check("to_no_valid", 32'(instr_valid), 32'd0);
        ext_ready = 1'b1; ext_rdata = 32'h0;
        tick();
        ext_ready = 1'b0;
        check("late_no_valid", 32'(instr_valid), 32'd0);
        check("late_no_done", 32'(dmem_done), 32'd0);
        tick();

        // Asynchronous reset in the middle of a read
        dmem_op = 2'd1; dmem_addr = 32'h44;
        tick();
        dmem_op = 2'd0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("ar_drive", 32'(ext_drive), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_instr", instr_out, 32'd0);
        check("ar_rdata", dmem_rdata, 32'd0);
        check("ar_addr", ext_addr, 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h500;
        tick();
        fetch_req = 1'b0;
        ext_ready = 1'b1; ext_rdata = 32'h0BADF00D;
        tick();
        ext_ready = 1'b0;
        check("ar_fetch", instr_out, 32'h0BADF00D);
        tick();

        // Second fetch into a full slot is dropped
        dmem_op = 2'd1; dmem_addr = 32'h48;
        tick();
        dmem_op = 2'd0;
        fetch_req = 1'b1; fetch_addr = 32'h600;
        tick();
        fetch_addr = 32'h700;
        tick();
        fetch_req = 1'b0;
        ext_ready = 1'b1;
        tick();
        ext_ready = 1'b0;
        tick();
        check("ov_addr", ext_addr, 32'h600);
        ext_ready = 1'b1; ext_rdata = 32'h66;
        tick();
        ext_ready = 1'b0;
        cnt = instr_valid ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (instr_valid) cnt++;
        end
        check("ov_pulses", 32'(cnt), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            fetch_req  = ($urandom_range(0, 3) == 0);
            fetch_addr = $urandom;
            dmem_op    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            dmem_addr  = $urandom;
            dmem_wdata = $urandom;
            ext_ready  = ($urandom_range(0, 2) == 0);
            ext_rdata  = $urandom;
            rst        = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; fetch_req = 1'b0; dmem_op = 2'd0; ext_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
